seq_pattern_tx: RTL and testbench

Serial pattern transmitter, the sending end of the team's serial bit-pattern detectors. It latches a PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per clock. The pattern is repeated a programmable number of times (or continuously), with optional idle gap cycles between repetitions. It drives detector inputs in loopback benches and serves as a stimulus/framing source on the serial data path.

---
 rtl/seq_pattern_tx.sv | 160 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a PAT_W-bit pattern on start and shifts it
// out MSB-first, repeated rep_cnt times (0 = until abort) with gap_len idle cycles between.
module seq_pattern_tx #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0]   gap_len_q, gap_len_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic               out_d, out_valid_d, frame_start_d, busy_d, done_d;
  logic [CNT_W-1:0]   rep_inc;
  logic               last_bit;

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    shift_d       = shift_q;
    rep_cnt_d     = rep_cnt_q;
    gap_len_d     = gap_len_q;
    bit_d         = bit_q;
    gap_d         = gap_q;
    rep_d         = rep_q;
    out_d         = 1'b0;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    rep_inc       = rep_q + CNT_W'(1);
    last_bit      = (bit_q == BIT_W'(PAT_W - 1));

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          pat_d         = pat_in;
          rep_cnt_d     = rep_cnt;
          gap_len_d     = gap_len;
          rep_d         = '0;
          bit_d         = '0;
          gap_d         = '0;
          shift_d       = {pat_in[PAT_W-2:0], 1'b0};
          out_d         = pat_in[PAT_W-1];
          out_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
          state_d       = SEND;
        end
      end

      SEND: begin
        if (abort) begin
          state_d = IDLE;
          bit_d   = '0;
        end else if (last_bit) begin
          rep_d = rep_inc;
          bit_d = '0;
          if ((rep_cnt_q != '0) && (rep_inc == rep_cnt_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (gap_len_q == '0) begin
            shift_d       = {pat_q[PAT_W-2:0], 1'b0};
            out_d         = pat_q[PAT_W-1];
            out_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            busy_d        = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = GAP_W'(1);
            busy_d  = 1'b1;
          end
        end else begin
          bit_d       = bit_q + BIT_W'(1);
          shift_d     = {shift_q[PAT_W-2:0], 1'b0};
          out_d       = shift_q[PAT_W-1];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
          gap_d   = '0;
        end else if (gap_q == gap_len_q) begin
          // Last gap cycle: the next cycle carries the MSB of the next repetition.
          state_d       = SEND;
          gap_d         = '0;
          shift_d       = {pat_q[PAT_W-2:0], 1'b0};
          out_d         = pat_q[PAT_W-1];
          out_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
        end else begin
          gap_d  = gap_q + GAP_W'(1);
          busy_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      shift_q     <= '0;
      rep_cnt_q   <= '0;
      gap_len_q   <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      rep_q       <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      shift_q     <= shift_d;
      rep_cnt_q   <= rep_cnt_d;
      gap_len_q   <= gap_len_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      rep_q       <= rep_d;
      out         <= out_d;
      out_valid   <= out_valid_d;
      frame_start <= frame_start_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: per-cycle comparison against a queue-based stream model,
// plus literal checks of bit streams, event cycles and a loopback 1011 detector.
module tb_seq_pattern_tx;
  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_W = 4;

  logic             clk, rst, start, abort;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             out, out_valid, frame_start, busy, done;

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pat_in(pat_in), .rep_cnt(rep_cnt), .gap_len(gap_len),
    .out(out), .out_valid(out_valid), .frame_start(frame_start),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic o; logic v; logic fs; logic b; logic d;} exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  logic [15:0] cap;
  int          cap_n, fs_n, done_n, done_cyc, det_n;
  logic [3:0]  det_sh;
  int          det_q[$];
  int          cs;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic clr_obs();
    cap = '0; cap_n = 0; fs_n = 0; done_n = 0; done_cyc = -1;
    det_n = 0; det_sh = '0; det_q.delete();
  endtask

  // Stream model: each repetition is PAT_W bit cycles, then gap idle-busy cycles,
  // the final repetition is followed by one done cycle instead of a gap.
  task automatic push_run(input logic [3:0] pat, input int rep, input int gap, input int max_n);
    int   n;
    int   r;
    exp_t e;
    n = 0; r = 0;
    while (n < max_n) begin
      for (int i = 0; i < 4; i++) begin
        e.o = pat[3-i]; e.v = 1'b1; e.fs = (i == 0); e.b = 1'b1; e.d = 1'b0;
        exp_q.push_back(e);
        n++;
      end
      r++;
      if (rep != 0 && r == rep) begin
        e = '0; e.d = 1'b1;
        exp_q.push_back(e);
        break;
      end
      for (int g = 0; g < gap; g++) begin
        e = '0; e.b = 1'b1;
        exp_q.push_back(e);
        n++;
      end
    end
  endtask

  task automatic arm(input logic [3:0] pat, input int rep, input int gap);
    start = 1'b1; pat_in = pat; rep_cnt = CNT_W'(rep); gap_len = GAP_W'(gap);
  endtask

  // Completes the start edge, loads the model and scrambles the inputs.
  task automatic launch(input logic [3:0] pat, input int rep, input int gap, input int max_n,
                        output int c0);
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc - 1;
    push_run(pat, rep, gap, max_n);
    pat_in = PAT_W'($urandom); rep_cnt = CNT_W'($urandom); gap_len = GAP_W'($urandom);
  endtask

  // Per-cycle compare against the model; idle expected when the model queue is empty.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '0;
      a = {out, out_valid, frame_start, busy, done};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_cmp @cyc %0d: got o/v/fs/b/d=%b, expected %b", cyc, a, e);
      end
      if (out_valid) begin
        cap = {cap[14:0], out}; cap_n++;
        det_sh = {det_sh[2:0], out}; det_n++;
        if (det_n >= 4 && det_sh == 4'b1011) begin
          det_q.push_back(cyc);
          det_n = 0;
        end
      end
      if (frame_start) fs_n++;
      if (done) begin done_n++; done_cyc = cyc; end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pat_in = '0; rep_cnt = '0; gap_len = '0;
    clr_obs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", int'({out, out_valid, frame_start, busy, done}), 0);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Single shot
    arm(4'b1011, 1, 0);
    launch(4'b1011, 1, 0, 1000, cs);
    repeat (5) @(posedge clk); #1;
    check("t1_bits_n", cap_n, 4);
    check("t1_bits", int'(cap[3:0]), 4'b1011);
    check("t1_done_cyc", done_cyc - cs, 5);
    check("t1_fs_n", fs_n, 1);
    check("t1_busy_after", int'(busy), 0);

    // Gapped repeats; the next run starts in the done cycle
    clr_obs();
    arm(4'b1011, 3, 2);
    launch(4'b1011, 3, 2, 1000, cs);
    repeat (16) @(posedge clk); #1;
    arm(4'b1011, 2, 0);
    #5;
    check("t2_bits_n", cap_n, 12);
    check("t2_bits", int'(cap[11:0]), 12'b1011_1011_1011);
    check("t2_fs_n", fs_n, 3);
    check("t2_done_cyc", done_cyc - cs, 17);
    clr_obs();

    // Back-to-back with loopback detector
    launch(4'b1011, 2, 0, 1000, cs);
    repeat (9) @(posedge clk); #1;
    check("t3_bits", int'(cap[7:0]), 8'b1011_1011);
    check("t3_done_cyc", done_cyc - cs, 9);
    check("t3_fs_n", fs_n, 2);
    check("t3_det_n", det_q.size(), 2);
    if (det_q.size() == 2) begin
      check("t3_det0_cyc", det_q[0] - cs, 4);
      check("t3_det1_cyc", det_q[1] - cs, 8);
    end

    // Continuous with gap, aborted at cycle 6
    clr_obs();
    arm(4'b1011, 0, 1);
    launch(4'b1011, 0, 1, 40, cs);
    repeat (5) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    check("t4_abort_idle", int'({out, out_valid, busy}), 0);
    repeat (5) @(posedge clk); #1;
    check("t4_done_n", done_n, 0);
    check("t4_fs_n", fs_n, 2);
    check("t4_bits_n", cap_n, 5);

    // Start while busy is ignored; start+abort in IDLE stays idle
    clr_obs();
    arm(4'b1011, 1, 0);
    launch(4'b1011, 1, 0, 1000, cs);
    @(posedge clk); #1;
    start = 1'b1; pat_in = 4'b0110; rep_cnt = 8'd5; gap_len = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t5_bits", int'(cap[3:0]), 4'b1011);
    check("t5_bits_n", cap_n, 4);
    check("t5_done_cyc", done_cyc - cs, 5);
    start = 1'b1; abort = 1'b1; pat_in = 4'b1111; rep_cnt = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("t5_sa_busy", int'(busy), 0);
    @(posedge clk); #1;
    check("t5_sa_busy2", int'({busy, out_valid}), 0);

    // Mid-run asynchronous reset, then a fresh start
    clr_obs();
    arm(4'b1011, 0, 0);
    launch(4'b1011, 0, 0, 40, cs);
    @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_async_rst", int'({out, out_valid, frame_start, busy, done}), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    clr_obs();
    arm(4'b1100, 1, 0);
    launch(4'b1100, 1, 0, 1000, cs);
    repeat (5) @(posedge clk); #1;
    check("t6_bits", int'(cap[3:0]), 4'b1100);
    check("t6_bits_n", cap_n, 4);
    check("t6_done_cyc", done_cyc - cs, 5);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
